stack_sequencer: RTL and testbench
==================================

Name: stack_sequencer

Overview:
Multi-cycle controller for the processor's stack pointer and stack memory port. It accepts push/pop requests from the memory stage, covering single 16-bit words (PUSH/POP) and 32-bit double words (CALL/RET/INT/RTI PC save/restore). It sequences the word-wide memory accesses, owns the SP register and stalls the pipeline until the sequence completes. SP uses post-decrement on push and pre-increment on pop: a push writes at SP then SP-1; a pop reads at SP+1 then SP+1.

Parameters:
SP_INIT, 32'h0000_0FFF, SP value after reset; top of stack; pops beyond it underflow
STACK_LIMIT, 32'h0000_0F00, lowest writable stack address; pushes below it overflow
WORD_W, 16, memory word width; double-word operations use 2*WORD_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_op  in  2  0=PUSH1, 1=POP1, 2=PUSH2, 3=POP2
req_ready  out  1  high only in IDLE; a request is accepted when req_valid&&req_ready
push_data  in  32  data to push; sampled at acceptance; PUSH1 uses [15:0]
mem_addr  out  32  stack memory address
mem_we  out  1  write strobe
mem_re  out  1  read strobe; mem_rdata is valid one cycle later
mem_wdata  out  16  write data
mem_rdata  in  16  read data
pop_data  out  32  popped value; POP1 zero-extends to 32 bits
pop_valid  out  1  one-cycle pulse when pop_data is valid
stall  out  1  high while state != IDLE
sp_out  out  32  current SP
fault  out  1  one-cycle pulse on overflow/underflow (see Optional Feature)

Behaviour:
- Reset: SP=SP_INIT, state=IDLE. All strobes, pop_valid, fault, mem_addr, mem_wdata and pop_data are 0. req_ready=1, stall=0.
- States: IDLE, PUSH_HI, PUSH_LO, POP_A, POP_B, POP_C.
- IDLE, on accept:
  - PUSH1: writes push_data[15:0] at SP in the same cycle (mem_we combinational from the accept); SP<=SP-1; stays in IDLE; latency 1, no stall.
  - PUSH2: latches push_data; -> PUSH_HI.
  - POP1: mem_re at SP+1; SP<=SP+1; -> POP_C.
  - POP2: -> POP_A.
- PUSH_HI: write hi word at SP; SP<=SP-1; -> PUSH_LO.
- PUSH_LO: write lo word at SP; SP<=SP-1; -> IDLE. PUSH2 total is 3 cycles including accept; final SP is SP0-2.
- POP_A: mem_re at SP+1 (lo word); SP<=SP+1; -> POP_B.
- POP_B: capture lo; mem_re at SP+1 (hi word); SP<=SP+1; -> POP_C.
- POP_C: capture the last word. pop_data becomes {hi,lo} for POP2 or {16'b0,word} for POP1, with pop_valid=1 in the following IDLE cycle (registered).
- Bounds (when the feature is enabled) are checked atomically at acceptance for all words of the request:
  - Push overflow: SP-(n-1) < STACK_LIMIT.
  - Pop underflow: SP+n > SP_INIT.
  - On violation: request consumed, no memory access, SP unchanged, fault=1 the next cycle, stay in IDLE.
- SP arithmetic is modulo 2^32.
- A new request may be accepted in the same IDLE cycle that pop_valid is asserted.
- rst mid-sequence forces IDLE and SP=SP_INIT. A partial push is not undone; a pending pop_valid is dropped.
- req_op/push_data are ignored when req_valid=0.

Optional Feature:
STACK_BOUNDS_CHECK_EN
- Defined: overflow/underflow checks as above; fault driven.
- Undefined: no checks; fault tied 0; SP wraps freely; out-of-range requests execute normally.

Decomposition:
- Package stack_seq_pkg holds the req_op encoding constants (OP_PUSH1..OP_POP2), the state enum, and the default SP_INIT/STACK_LIMIT constants shared with the decode stage.
- One sub-module, stack_addr_gen (combinational): takes SP, op and word index; produces the access address, next SP and the overflow/underflow flags.

Test Plan:
1. Reset, then PUSH1 with push_data=32'h0000_ABCD -> mem_we=1, mem_addr=0FFF, mem_wdata=ABCD in the accept cycle; sp_out=0FFE next; stall never asserted.
2. PUSH2 with 32'h1234_5678 from SP=0FFF -> writes 1234@0FFF, then 5678@0FFE; stall=1 for 2 cycles; SP=0FFD.
3. After test 2, POP2 -> reads @0FFE then @0FFF; pop_data=32'h1234_5678, pop_valid for one cycle; SP=0FFF; req_ready=0 until IDLE.
4. With STACK_BOUNDS_CHECK_EN, POP1 at SP=0FFF -> no mem_re, fault pulse, SP=0FFF. PUSH2 at SP=0F00 -> fault, no mem_we, SP=0F00.
5. Assert rst in the cycle after PUSH2 is accepted from SP=0FFF -> hi word written at most once; next cycle SP=0FFF, state IDLE, stall=0, no pop_valid/fault.
6. Back-to-back POP1 requested in the pop_valid cycle after a prior POP1 -> accepted immediately; two pop_valid pulses separated by exactly 2 cycles.

Source files
------------

// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack sequencer and the decode stage:
// request opcode encoding, sequencer state set and default stack bounds.
package stack_seq_pkg;

  localparam logic [1:0] OP_PUSH1 = 2'd0;
  localparam logic [1:0] OP_POP1  = 2'd1;
  localparam logic [1:0] OP_PUSH2 = 2'd2;
  localparam logic [1:0] OP_POP2  = 2'd3;

  localparam logic [31:0] DEF_SP_INIT     = 32'h0000_0FFF;
  localparam logic [31:0] DEF_STACK_LIMIT = 32'h0000_0F00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_POP_A,
    ST_POP_B,
    ST_POP_C
  } state_t;

  // Bit 0 of the opcode selects pop, bit 1 selects the double-word form.
  function automatic logic op_is_pop(input logic [1:0] op);
    return op[0];
  endfunction

  function automatic logic op_is_double(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/stack_addr_gen.sv
// Stack address generator (combinational). Given the SP at acceptance of a
// request, the opcode and the index of the word being transferred, produces
// the memory address, the SP after that word, and the bounds flags for the
// whole request (post-decrement push, pre-increment pop, modulo 2^32).
module stack_addr_gen
  import stack_seq_pkg::*;
#(
  parameter logic [31:0] SP_INIT     = DEF_SP_INIT,
  parameter logic [31:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
  input  logic [31:0] sp,
  input  logic [1:0]  op,
  input  logic        word_idx,
  output logic [31:0] addr,
  output logic [31:0] sp_next,
  output logic        overflow,
  output logic        underflow
);

  logic [31:0] idx32;
  logic [31:0] extra;

  // Address / next-SP for the indexed word, and request-wide bounds flags.
  always_comb begin
    idx32     = {31'd0, word_idx};
    extra     = {31'd0, op_is_double(op)};
    addr      = '0;
    sp_next   = '0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (op_is_pop(op)) begin
      addr      = sp + 32'd1 + idx32;
      sp_next   = addr;
      underflow = (sp + extra + 32'd1) > SP_INIT;
    end else begin
      addr      = sp - idx32;
      sp_next   = addr - 32'd1;
      overflow  = (sp - extra) < STACK_LIMIT;
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// Stack sequencer: owns SP and sequences word-wide stack memory accesses for
// single-word (PUSH1/POP1) and double-word (PUSH2/POP2) requests, stalling
// the pipeline until the sequence completes.
// Optional feature macro: STACK_BOUNDS_CHECK_EN (overflow/underflow faults).
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter logic [31:0] SP_INIT     = DEF_SP_INIT,
  parameter logic [31:0] STACK_LIMIT = DEF_STACK_LIMIT,
  parameter int unsigned WORD_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  output logic                  req_ready,
  input  logic [2*WORD_W-1:0]   push_data,
  output logic [31:0]           mem_addr,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata,
  output logic [2*WORD_W-1:0]   pop_data,
  output logic                  pop_valid,
  output logic                  stall,
  output logic [31:0]           sp_out,
  output logic                  fault
);

  state_t              state, state_d;
  logic [31:0]         sp, sp_d;
  logic [31:0]         base_q;
  logic [1:0]          op_q;
  logic [2*WORD_W-1:0] data_q;
  logic [WORD_W-1:0]   lo_q;

  logic        accept;
  logic        bounds_err;
  logic [31:0] gen_sp, gen_addr, gen_sp_next;
  logic [1:0]  gen_op;
  logic        gen_idx;
  logic        ovf, unf;

  assign req_ready = (state == ST_IDLE);
  assign stall     = (state != ST_IDLE);
  assign sp_out    = sp;
  assign accept    = req_valid && req_ready;

  // Addresses are generated from the SP captured at acceptance plus the word
  // index, so multi-cycle sequences do not depend on the live SP register.
  assign gen_sp  = (state == ST_IDLE) ? sp : base_q;
  assign gen_op  = (state == ST_IDLE) ? req_op : op_q;
  assign gen_idx = (state == ST_PUSH_LO) || (state == ST_POP_B);

  stack_addr_gen #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_addr_gen (
    .sp        (gen_sp),
    .op        (gen_op),
    .word_idx  (gen_idx),
    .addr      (gen_addr),
    .sp_next   (gen_sp_next),
    .overflow  (ovf),
    .underflow (unf)
  );

`ifdef STACK_BOUNDS_CHECK_EN
  assign bounds_err = accept && (ovf || unf);
`else
  logic unused_bounds;
  assign unused_bounds = ovf | unf;
  assign bounds_err    = 1'b0;
`endif

  // Next-state, SP update and memory strobes.
  always_comb begin
    state_d   = state;
    sp_d      = sp;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (accept && !bounds_err) begin
          case (req_op)
            OP_PUSH1: begin
              mem_we    = 1'b1;
              mem_addr  = gen_addr;
              mem_wdata = push_data[WORD_W-1:0];
              sp_d      = gen_sp_next;
            end
            OP_POP1: begin
              mem_re   = 1'b1;
              mem_addr = gen_addr;
              sp_d     = gen_sp_next;
              state_d  = ST_POP_C;
            end
            OP_PUSH2: state_d = ST_PUSH_HI;
            OP_POP2:  state_d = ST_POP_A;
          endcase
        end
      end
      ST_PUSH_HI: begin
        mem_we    = 1'b1;
        mem_addr  = gen_addr;
        mem_wdata = data_q[2*WORD_W-1:WORD_W];
        sp_d      = gen_sp_next;
        state_d   = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        mem_we    = 1'b1;
        mem_addr  = gen_addr;
        mem_wdata = data_q[WORD_W-1:0];
        sp_d      = gen_sp_next;
        state_d   = ST_IDLE;
      end
      ST_POP_A: begin
        mem_re   = 1'b1;
        mem_addr = gen_addr;
        sp_d     = gen_sp_next;
        state_d  = ST_POP_B;
      end
      ST_POP_B: begin
        mem_re   = 1'b1;
        mem_addr = gen_addr;
        sp_d     = gen_sp_next;
        state_d  = ST_POP_C;
      end
      ST_POP_C: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, SP and request context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sp     <= SP_INIT;
      base_q <= '0;
      op_q   <= OP_PUSH1;
      data_q <= '0;
    end else begin
      state <= state_d;
      sp    <= sp_d;
      if (accept) begin
        base_q <= sp;
        op_q   <= req_op;
        data_q <= push_data;
      end
    end
  end

  // Pop result assembly and the one-cycle pop_valid / fault pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q      <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pop_valid <= (state == ST_POP_C);
      fault     <= bounds_err;
      if (state == ST_POP_B) lo_q <= mem_rdata;
      if (state == ST_POP_C) begin
        pop_data <= op_is_double(op_q) ? {mem_rdata, lo_q}
                                       : {{WORD_W{1'b0}}, mem_rdata};
      end
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: directed scenarios plus random
// request streams compared against a transaction-level stack model.
// Honours STACK_BOUNDS_CHECK_EN in the model when defined.
module tb_stack_sequencer;
  import stack_seq_pkg::*;

  localparam logic [31:0] SP_INIT     = DEF_SP_INIT;
  localparam logic [31:0] STACK_LIMIT = DEF_STACK_LIMIT;

  logic        clk, rst, req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] push_data, mem_addr, pop_data, sp_out;
  logic        mem_we, mem_re, pop_valid, stall, fault;
  logic [15:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: SP and word-addressed memory contents.
  logic [31:0] model_sp;
  logic [15:0] mmem [logic [31:0]];

  stack_sequencer #(
    .SP_INIT     (SP_INIT),
    .STACK_LIMIT (STACK_LIMIT),
    .WORD_W      (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .push_data (push_data),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .stall     (stall),
    .sp_out    (sp_out),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mread(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : 16'h0000;
  endfunction

  // Memory responder: read data one cycle after the strobe, from the model.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mread(mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_sp = SP_INIT;
  endtask

  task automatic check_reset();
    @(negedge clk);
    check("rst_sp",        sp_out,    SP_INIT);
    check("rst_ready",     req_ready, 1);
    check("rst_stall",     stall,     0);
    check("rst_we",        mem_we,    0);
    check("rst_re",        mem_re,    0);
    check("rst_addr",      mem_addr,  0);
    check("rst_wdata",     mem_wdata, 0);
    check("rst_pop_data",  pop_data,  0);
    check("rst_pop_valid", pop_valid, 0);
    check("rst_fault",     fault,     0);
    @(posedge clk);
    #1;
  endtask

  // Issue one request, observe until the sequencer is ready again, compare.
  task automatic run_req(input logic [1:0] op, input logic [31:0] d);
    int unsigned n;
    logic        pop, viol;
    logic [31:0] sp0, exp_pd;
    logic [31:0] ea [2];
    logic [15:0] ed [2];
    int          exp_wn, exp_rn, exp_busy;
    logic [31:0] wa [4];
    logic [15:0] wd [4];
    logic [31:0] ra [4];
    int          wn, rn, busy;
    logic        ready_ok, done, s_pv, s_f;
    logic [31:0] s_pd, s_sp;

    n   = op[1] ? 2 : 1;
    pop = op[0];
    sp0 = model_sp;
`ifdef STACK_BOUNDS_CHECK_EN
    viol = pop ? ((sp0 + n) > SP_INIT) : ((sp0 - (n - 1)) < STACK_LIMIT);
`else
    viol = 1'b0;
`endif
    exp_wn = 0; exp_rn = 0; exp_busy = 0; exp_pd = '0;
    ea[0] = '0; ea[1] = '0; ed[0] = '0; ed[1] = '0;
    if (!viol) begin
      if (!pop) begin
        ea[0] = sp0;
        if (n == 1) begin
          ed[0] = d[15:0];
          exp_wn = 1;
        end else begin
          ed[0] = d[31:16];
          ea[1] = sp0 - 1;
          ed[1] = d[15:0];
          exp_wn = 2;
          exp_busy = 2;
        end
        for (int i = 0; i < exp_wn; i++) mmem[ea[i]] = ed[i];
        model_sp = sp0 - n;
      end else begin
        ea[0] = sp0 + 1;
        ea[1] = sp0 + 2;
        exp_rn = n;
        exp_pd = (n == 1) ? {16'h0000, mread(sp0 + 1)} : {mread(sp0 + 2), mread(sp0 + 1)};
        exp_busy = (n == 1) ? 1 : 3;
        model_sp = sp0 + n;
      end
    end

    req_valid = 1'b1; req_op = op; push_data = d;
    wn = 0; rn = 0; busy = 0; ready_ok = 1'b1; done = 1'b0;
    s_pv = 1'b0; s_f = 1'b0; s_pd = '0; s_sp = '0;
    for (int cyc = 0; cyc < 10 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("accept_ready", req_ready, 1);
        check("accept_pop_valid", pop_valid, 0);
        check("accept_fault", fault, 0);
      end
      if (cyc > 0 && req_ready) begin
        done = 1'b1;
        s_pv = pop_valid; s_f = fault; s_pd = pop_data; s_sp = sp_out;
      end else begin
        if (stall) busy++;
        if (stall == req_ready) ready_ok = 1'b0;
        if (mem_we) begin
          if (wn < 4) begin wa[wn] = mem_addr; wd[wn] = mem_wdata; end
          wn++;
        end
        if (mem_re) begin
          if (rn < 4) ra[rn] = mem_addr;
          rn++;
        end
      end
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        req_valid = 1'b0;
        req_op = 2'($urandom);
        push_data = $urandom;
      end
    end

    check("done", done, 1);
    check("busy_cycles", busy, exp_busy);
    check("ready_vs_stall", ready_ok, 1);
    check("wr_count", wn, exp_wn);
    for (int i = 0; i < exp_wn && i < wn; i++) begin
      check("wr_addr", wa[i], ea[i]);
      check("wr_data", wd[i], ed[i]);
    end
    check("rd_count", rn, exp_rn);
    for (int i = 0; i < exp_rn && i < rn; i++) check("rd_addr", ra[i], ea[i]);
    check("sp", s_sp, model_sp);
    check("fault", s_f, viol);
    check("pop_valid", s_pv, pop && !viol);
    if (pop && !viol) check("pop_data", s_pd, exp_pd);
  endtask

  initial begin
    int          wn5, pv_n;
    int          pk [2];
    logic [31:0] pdv [2];
    logic [1:0]  rop;

    rst = 1'b1; req_valid = 1'b0; req_op = '0; push_data = '0;
    model_sp = SP_INIT;
    @(posedge clk);
    #1;

    // Reset state, then a single-word push.
    do_reset();
    check_reset();
    run_req(OP_PUSH1, 32'h0000_ABCD);

    // Double-word push then double-word pop of the same value.
    do_reset();
    run_req(OP_PUSH2, 32'h1234_5678);
    run_req(OP_POP2, $urandom);

    // Bounds boundaries: pop at top, fill to the limit, push past it.
    do_reset();
    run_req(OP_POP1, $urandom);
    for (int i = 0; i < 255; i++) run_req(OP_PUSH1, $urandom);
    check("sp_at_limit", sp_out, model_sp);
    run_req(OP_PUSH2, 32'hDEAD_BEEF);
    run_req(OP_PUSH1, 32'h0000_5A5A);
    run_req(OP_PUSH1, 32'h0000_A5A5);

    // Reset in the cycle after a PUSH2 is accepted.
    do_reset();
    wn5 = 0;
    req_valid = 1'b1; req_op = OP_PUSH2; push_data = 32'hCAFE_BEEF;
    @(negedge clk);
    if (mem_we) wn5++;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    if (mem_we) wn5++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    if (mem_we) wn5++;
    check("rst_mid_sp", sp_out, SP_INIT);
    check("rst_mid_stall", stall, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_pop_valid", pop_valid, 0);
    check("rst_mid_fault", fault, 0);
    check("rst_mid_writes_le1", wn5 <= 1, 1);
    @(posedge clk);
    #1;
    model_sp = SP_INIT;
    mmem[32'h0000_0FFF] = 16'hCAFE;

    // Back-to-back POP1 accepted in the pop_valid cycle.
    do_reset();
    run_req(OP_PUSH1, 32'h0000_1111);
    run_req(OP_PUSH1, 32'h0000_2222);
    pv_n = 0; pk[0] = -1; pk[1] = -1; pdv[0] = '0; pdv[1] = '0;
    req_valid = 1'b1; req_op = OP_POP1; push_data = $urandom;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (pop_valid) begin
        if (pv_n < 2) begin pk[pv_n] = k; pdv[pv_n] = pop_data; end
        pv_n++;
      end
      if (k == 2) check("b2b_ready", req_ready, 1);
      @(posedge clk);
      #1;
      if (k == 2) req_valid = 1'b0;
    end
    model_sp = model_sp + 2;
    check("b2b_pulses", pv_n, 2);
    check("b2b_first_at", pk[0], 2);
    check("b2b_gap", pk[1] - pk[0], 2);
    check("b2b_data0", pdv[0], 32'h0000_2222);
    check("b2b_data1", pdv[1], 32'h0000_1111);
    check("b2b_sp", sp_out, model_sp);

    // Random request stream with idle gaps and junk inputs while invalid.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rop = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) begin
        req_op = 2'($urandom);
        push_data = $urandom;
        @(posedge clk);
        #1;
      end
      run_req(rop, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
